// File: rtl/regfile_scoreboard.sv
// Two-read/two-write register file with optional write-to-read bypass and a per-register busy scoreboard.
// Reads and busy lookups are combinational; storage, busy and pending update one edge later; no backpressure.
module regfile_scoreboard #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'h00000800,
  parameter int          BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_reg,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pending
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_RESET);

  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   pending_nxt;

  // Port 1 beats port 0 both for forwarding and for same-address stores.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    if (!rd_en || ra == '0) return '0;
    if (BYPASS != 0 && we1 && wa1 == ra) return wd1;
    if (BYPASS != 0 && we0 && wa0 == ra) return wd0;
    return regs[ra];
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  // A new issue outranks a same-cycle writeback: the later producer owns the register.
  always_comb begin
    busy_nxt    = '0;
    pending_nxt = '0;
    for (int r = 1; r < DEPTH; r++) begin
      busy_nxt[r] = (iss_valid && iss_reg == ADDR_W'(r)) ||
                    (busy[r] && !((we0 && wa0 == ADDR_W'(r)) || (we1 && wa1 == ADDR_W'(r))));
      pending_nxt = pending_nxt + (ADDR_W+1)'(busy_nxt[r]);
    end
  end

  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < DEPTH; r++) begin
        regs[r] <= (r == SP_INDEX) ? SP_INIT : '0;
      end
      busy    <= '0;
      pending <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (we1 && wa1 == ADDR_W'(r)) begin
          regs[r] <= wd1;
        end else if (we0 && wa0 == ADDR_W'(r)) begin
          regs[r] <= wd0;
        end
      end
      busy    <= busy_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a randomized scoreboard run.
// Two instances share stimulus: one with bypass enabled, one without.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic        rd_en;
  logic [4:0]  ra1, ra2, wa0, wa1, iss_reg;
  logic        we0, we1, iss_valid;
  logic [31:0] wd0, wd1;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, busy1_nb, busy2_nb;
  logic [5:0]  pending, pending_nb;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic [5:0]  pending;
    logic [31:0] rd1_nb;
    logic [31:0] rd2_nb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  int          m_pend;

  regfile_scoreboard #(.BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .busy1(busy1), .busy2(busy2), .pending(pending)
  );

  regfile_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .rd_en(rd_en), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .busy1(busy1_nb), .busy2(busy2_nb), .pending(pending_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    iss_valid = 0; iss_reg = 0; rd_en = 1;
  endtask

  task automatic test_reset();
    idle();
    ra1 = 0; ra2 = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    for (int r = 0; r < 32; r++) begin
      logic [31:0] exp_v;
      exp_v = (r == 29) ? 32'h00000800 : 32'h0;
      ra1 = 5'(r); ra2 = 5'(31 - r);
      #1;
      checks++;
      if (rd1 !== exp_v) begin failures++; $display("FAIL reset_rd1 r=%0d got=%h exp=%h", r, rd1, exp_v); end
      checks++;
      if (rd2 !== ((31 - r == 29) ? 32'h00000800 : 32'h0)) begin
        failures++; $display("FAIL reset_rd2 r=%0d got=%h", 31 - r, rd2);
      end
      checks++;
      if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 r=%0d got=%b exp=0", r, busy1); end
    end
    checks++;
    if (pending !== 6'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    // Writes to r0 are dropped and r0 always reads zero.
    we0 = 1; wa0 = 0; wd0 = 32'hDEADBEEF; ra1 = 0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%h exp=0", rd1); end
    tick();
    idle();
    #1;
    checks++;
    if (rd1 !== 32'h0) begin failures++; $display("FAIL r0_read got=%h exp=0", rd1); end
  endtask

  task automatic test_dual_write();
    idle();
    we0 = 1; wa0 = 5; wd0 = 32'h99;
    tick();
    idle();
    we0 = 1; wa0 = 5; wd0 = 32'h11;
    we1 = 1; wa1 = 5; wd1 = 32'h22;
    ra1 = 5;
    #1;
    checks++;
    if (rd1 !== 32'h22) begin failures++; $display("FAIL dual_bypass got=%h exp=22", rd1); end
    checks++;
    if (rd1_nb !== 32'h99) begin failures++; $display("FAIL dual_nobypass got=%h exp=99", rd1_nb); end
    tick();
    idle();
    #1;
    checks++;
    if (rd1 !== 32'h22) begin failures++; $display("FAIL dual_stored got=%h exp=22", rd1); end
    checks++;
    if (rd1_nb !== 32'h22) begin failures++; $display("FAIL dual_stored_nb got=%h exp=22", rd1_nb); end
  endtask

  task automatic test_rd_en();
    idle();
    ra1 = 29; rd_en = 0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin failures++; $display("FAIL rd_en_off got=%h exp=0", rd1); end
    rd_en = 1;
    #1;
    checks++;
    if (rd1 !== 32'h00000800) begin failures++; $display("FAIL rd_en_on got=%h exp=800", rd1); end
  endtask

  task automatic test_scoreboard();
    logic [5:0] exp_p [3];
    logic [4:0] seq [3];
    seq[0] = 3; seq[1] = 7; seq[2] = 3;
    exp_p[0] = 1; exp_p[1] = 2; exp_p[2] = 2;
    idle();
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1; iss_reg = seq[i];
      tick();
      checks++;
      if (pending !== exp_p[i]) begin failures++; $display("FAIL issue_pending step=%0d got=%0d exp=%0d", i, pending, exp_p[i]); end
    end
    idle();
    ra1 = 3; ra2 = 7;
    #1;
    checks++;
    if ({busy1, busy2} !== 2'b11) begin failures++; $display("FAIL busy_after_issue got=%b exp=11", {busy1, busy2}); end
    we0 = 1; wa0 = 3; wd0 = 32'h33;
    tick();
    idle();
    #1;
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL wb_clear got=%b exp=0", busy1); end
    checks++;
    if (pending !== 6'd1) begin failures++; $display("FAIL wb_pending got=%0d exp=1", pending); end
    // Issue and writeback to r7 together; forwarded data is visible while still busy.
    iss_valid = 1; iss_reg = 7; we1 = 1; wa1 = 7; wd1 = 32'h77;
    #1;
    checks++;
    if (rd2 !== 32'h77 || busy2 !== 1'b1) begin
      failures++; $display("FAIL fwd_while_busy rd2=%h busy2=%b exp rd2=77 busy2=1", rd2, busy2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy2 !== 1'b1) begin failures++; $display("FAIL issue_wins got=%b exp=1", busy2); end
    checks++;
    if (pending !== 6'd1) begin failures++; $display("FAIL issue_wins_pending got=%0d exp=1", pending); end
  endtask

  task automatic test_reset_mid();
    idle();
    iss_valid = 1; iss_reg = 9;
    tick();
    idle();
    checks++;
    if (pending !== 6'd2) begin failures++; $display("FAIL mid_pre_pending got=%0d exp=2", pending); end
    reset = 1;
    we0 = 1; wa0 = 9; wd0 = 32'h7;
    #1;
    checks++;
    if (pending !== 6'd0) begin failures++; $display("FAIL mid_async_pending got=%0d exp=0", pending); end
    tick();
    reset = 0;
    idle();
    ra1 = 9;
    #1;
    checks++;
    if (busy1 !== 1'b0 || rd1 !== 32'h0) begin
      failures++; $display("FAIL mid_cleared busy1=%b rd1=%h exp busy1=0 rd1=0", busy1, rd1);
    end
    we0 = 1; wa0 = 9; wd0 = 32'h5;
    tick();
    idle();
    #1;
    checks++;
    if (rd1 !== 32'h5) begin failures++; $display("FAIL mid_wb_data got=%h exp=5", rd1); end
    checks++;
    if (pending !== 6'd0) begin failures++; $display("FAIL mid_no_underflow got=%0d exp=0", pending); end
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] ra, input bit byp);
    if (!rd_en || ra == 0) return 32'h0;
    if (byp && we1 && wa1 == ra) return wd1;
    if (byp && we0 && wa0 == ra) return wd0;
    return m_regs[ra];
  endfunction

  task automatic test_random();
    exp_t e;
    idle();
    reset = 1;
    tick();
    reset = 0;
    for (int r = 0; r < 32; r++) m_regs[r] = (r == 29) ? 32'h00000800 : 32'h0;
    m_busy = 0;
    m_pend = 0;
    for (int c = 0; c < 10000; c++) begin
      rd_en = ($urandom_range(0, 7) != 0);
      ra1 = rand_addr(); ra2 = rand_addr();
      we0 = 1'($urandom_range(0, 1)); wa0 = rand_addr(); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = rand_addr(); wd1 = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_reg = rand_addr();
      e.rd1 = model_rd(ra1, 1);
      e.rd2 = model_rd(ra2, 1);
      e.rd1_nb = model_rd(ra1, 0);
      e.rd2_nb = model_rd(ra2, 0);
      e.busy1 = (ra1 != 0) && m_busy[ra1];
      e.busy2 = (ra2 != 0) && m_busy[ra2];
      e.pending = 6'(m_pend);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (rd1 !== e.rd1) begin failures++; $display("FAIL rand_rd1 cyc=%0d got=%h exp=%h", c, rd1, e.rd1); end
      checks++;
      if (rd2 !== e.rd2) begin failures++; $display("FAIL rand_rd2 cyc=%0d got=%h exp=%h", c, rd2, e.rd2); end
      checks++;
      if (rd1_nb !== e.rd1_nb) begin failures++; $display("FAIL rand_rd1_nb cyc=%0d got=%h exp=%h", c, rd1_nb, e.rd1_nb); end
      checks++;
      if (rd2_nb !== e.rd2_nb) begin failures++; $display("FAIL rand_rd2_nb cyc=%0d got=%h exp=%h", c, rd2_nb, e.rd2_nb); end
      checks++;
      if (busy1 !== e.busy1) begin failures++; $display("FAIL rand_busy1 cyc=%0d got=%b exp=%b", c, busy1, e.busy1); end
      checks++;
      if (busy2 !== e.busy2) begin failures++; $display("FAIL rand_busy2 cyc=%0d got=%b exp=%b", c, busy2, e.busy2); end
      checks++;
      if (pending !== e.pending) begin failures++; $display("FAIL rand_pending cyc=%0d got=%0d exp=%0d", c, pending, e.pending); end
      @(posedge clk);
      for (int r = 1; r < 32; r++) begin
        if ((we0 && wa0 == 5'(r)) || (we1 && wa1 == 5'(r))) m_busy[r] = 1'b0;
        if (iss_valid && iss_reg == 5'(r)) m_busy[r] = 1'b1;
      end
      if (we0 && wa0 != 0) m_regs[wa0] = wd0;
      if (we1 && wa1 != 0) m_regs[wa1] = wd1;
      m_pend = $countones(m_busy);
      #1;
    end
    idle();
  endtask

  initial begin
    reset = 1;
    ra1 = 0; ra2 = 0;
    idle();
    test_reset();
    test_dual_write();
    test_rd_en();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
